// File: rtl/repairclk_pkg.sv
// repairclk_pkg
// Shared types and constants for the clock-repair pattern detector:
// lane-checker state encoding, lane bit positions in the result vector,
// and the default pattern/window geometry.
package repairclk_pkg;

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      BURST = 2'd1,
      LOW   = 2'd2
   } lane_state_e;

   localparam int RCKP      = 0;
   localparam int RCKN      = 1;
   localparam int RTRK      = 2;
   localparam int NUM_LANES = 3;

   localparam int DEF_TOGGLE_LEN    = 16;
   localparam int DEF_LOW_LEN       = 8;
   localparam int DEF_PASS_THRESH   = 16;
   localparam int DEF_WINDOW_CYCLES = 3200;

endpackage

// File: rtl/repairclk_lane_checker.sv
// repairclk_lane_checker
// Checks one received lane against the repair pattern: a burst of TOGGLE_LEN
// alternating samples starting with 1, followed by LOW_LEN zeros. Counts
// consecutive good iterations and latches a sticky pass flag once the count
// reaches PASS_THRESH.
//
// Ports
//   i_clk        clock
//   i_rst        synchronous active-high reset
//   i_detect_en  detection enabled; low holds the checker idle
//   i_run        enabled and window still open; low freezes the checker
//   i_clear_log  clears the run count and sticky flag
//   i_sample     one lane sample per clock
//   o_logged     sticky pass flag
//
// state | meaning
// ------+------------------------------------------------------------
// HUNT  | waiting for a 1 that follows a 0 (start of a burst)
// BURST | checking alternating samples, idx = expected burst index
// LOW   | checking the trailing zeros, idx = zeros seen so far
module repairclk_lane_checker
   import repairclk_pkg::*;
#(
   parameter int TOGGLE_LEN  = DEF_TOGGLE_LEN,
   parameter int LOW_LEN     = DEF_LOW_LEN,
   parameter int PASS_THRESH = DEF_PASS_THRESH
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_detect_en,
   input  logic i_run,
   input  logic i_clear_log,
   input  logic i_sample,
   output logic o_logged
);

   localparam int IDX_MAX = (TOGGLE_LEN > LOW_LEN) ? TOGGLE_LEN : LOW_LEN;
   localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;
   localparam int CNT_W   = $clog2(PASS_THRESH + 1);

   localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
   localparam logic [IDX_W-1:0] BURST_LAST = IDX_W'(TOGGLE_LEN - 1);
   localparam logic [IDX_W-1:0] LOW_LAST   = IDX_W'(LOW_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(PASS_THRESH);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   lane_state_e      state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             prev_q;
   logic             logged_q;
   logic             miss;
   logic             good;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      miss    = 1'b0;
      good    = 1'b0;
      case (state_q)
         HUNT: begin
            // the sample that starts a burst is index 0, so the next one is 1
            if (i_sample && !prev_q) begin
               state_d = BURST;
               idx_d   = IDX_ONE;
            end
         end
         BURST: begin
            if (i_sample == ~idx_q[0]) begin
               if (idx_q == BURST_LAST) begin
                  state_d = LOW;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_ONE;
               end
            end else begin
               miss = 1'b1;
            end
         end
         LOW: begin
            if (!i_sample) begin
               if (idx_q == LOW_LAST) begin
                  // HUNT treats the next sample as burst index 0, since the
                  // previous sample is known to be 0
                  state_d = HUNT;
                  idx_d   = '0;
                  good    = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_ONE;
               end
            end else begin
               miss = 1'b1;
            end
         end
         default: begin
            state_d = HUNT;
            idx_d   = '0;
         end
      endcase

      if (miss) begin
         cnt_d = '0;
         // a wrong 1 is taken as the start of a fresh burst
         if (i_sample) begin
            state_d = BURST;
            idx_d   = IDX_ONE;
         end else begin
            state_d = HUNT;
            idx_d   = '0;
         end
      end else if (good && (cnt_q != CNT_SAT)) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= HUNT;
         idx_q    <= '0;
         cnt_q    <= '0;
         prev_q   <= 1'b0;
         logged_q <= 1'b0;
      end else begin
         if (!i_detect_en) begin
            state_q <= HUNT;
            idx_q   <= '0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
         end else if (i_run) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            prev_q  <= i_sample;
         end
         if (i_clear_log) begin
            cnt_q <= '0;
         end
         // clear beats a pass landing in the same cycle
         if (i_clear_log) begin
            logged_q <= 1'b0;
         end else if (i_run && (cnt_q == CNT_SAT)) begin
            logged_q <= 1'b1;
         end
      end
   end

   assign o_logged = logged_q;

endmodule

// File: rtl/repairclk_detector.sv
// repairclk_detector
// Detects the clock-repair pattern on the RCKP, RCKN and RTRK lanes during a
// fixed detection window and reports a sticky pass flag per lane.
//
// Ports
//   i_clk             clock
//   i_rst             synchronous active-high reset
//   i_detect_en       level, high while the repair pattern is expected
//   i_clear_log       one-cycle pulse, clears results and run counts
//   i_rckp/rckn/rtrk  one sample per clock per lane
//   o_logged_results  sticky pass flags {RTRK, RCKN, RCKP}
//   o_detect_done     window expired, held until i_detect_en falls
module repairclk_detector
   import repairclk_pkg::*;
#(
   parameter int TOGGLE_LEN    = DEF_TOGGLE_LEN,
   parameter int LOW_LEN       = DEF_LOW_LEN,
   parameter int PASS_THRESH   = DEF_PASS_THRESH,
   parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_detect_en,
   input  logic       i_clear_log,
   input  logic       i_rckp,
   input  logic       i_rckn,
   input  logic       i_rtrk,
   output logic [2:0] o_logged_results,
   output logic       o_detect_done
);

   localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
   localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

   logic [WIN_W-1:0]     win_cnt_q;
   logic                 done_q;
   logic                 run;
   logic [NUM_LANES-1:0] lane_sample;
   logic [NUM_LANES-1:0] lane_logged;

   // count is 0 on the first enabled cycle; it parks at the last value once done
   always_ff @(posedge i_clk) begin
      if (i_rst || !i_detect_en) begin
         win_cnt_q <= '0;
         done_q    <= 1'b0;
      end else if (!done_q) begin
         if (win_cnt_q == WIN_LAST) begin
            done_q <= 1'b1;
         end else begin
            win_cnt_q <= win_cnt_q + WIN_ONE;
         end
      end
   end

   assign run = i_detect_en & ~done_q;

   assign lane_sample[RCKP] = i_rckp;
   assign lane_sample[RCKN] = i_rckn;
   assign lane_sample[RTRK] = i_rtrk;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      repairclk_lane_checker #(
         .TOGGLE_LEN  (TOGGLE_LEN),
         .LOW_LEN     (LOW_LEN),
         .PASS_THRESH (PASS_THRESH)
      ) u_lane (
         .i_clk       (i_clk),
         .i_rst       (i_rst),
         .i_detect_en (i_detect_en),
         .i_run       (run),
         .i_clear_log (i_clear_log),
         .i_sample    (lane_sample[g]),
         .o_logged    (lane_logged[g])
      );
   end

   assign o_logged_results = lane_logged;
   assign o_detect_done    = done_q;

endmodule

// File: tb/tb_repairclk_detector.sv
module tb_repairclk_detector;
   import repairclk_pkg::*;

   localparam int WIN      = DEF_WINDOW_CYCLES;
   localparam int ITER     = DEF_TOGGLE_LEN + DEF_LOW_LEN;
   localparam int NEVER    = 1 << 30;
   localparam int K_IDEAL  = 0;
   localparam int K_STUCK0 = 1;
   localparam int K_STUCK1 = 2;
   localparam int K_FLIP10 = 3;
   localparam int K_FLIP15 = 4;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       en   = 1'b0;
   logic       clr  = 1'b0;
   logic       rckp = 1'b0;
   logic       rckn = 1'b0;
   logic       rtrk = 1'b0;
   logic [2:0] logged;
   logic       done;

   always #5 clk = ~clk;

   repairclk_detector dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_detect_en      (en),
      .i_clear_log      (clr),
      .i_rckp           (rckp),
      .i_rckn           (rckn),
      .i_rtrk           (rtrk),
      .o_logged_results (logged),
      .o_detect_done    (done)
   );

   typedef struct {
      int         cyc;
      logic [2:0] lg;
      logic       dn;
      string      tag;
   } exp_t;

   typedef struct {
      string      name;
      int         kp, kn, kt;
      int         pp, pn, pt;
      logic [2:0] final_lg;
   } scen_t;

   exp_t sb_q[$];
   int   n_cmp   = 0;
   int   n_bad   = 0;
   int   tick_no = 0;

   // ideal pattern: 16 alternating samples starting with 1, then 8 zeros
   function automatic logic pat_bit(input int kind, input int rel);
      int   it;
      int   pos;
      logic b;
      it  = rel / ITER;
      pos = rel % ITER;
      b   = (pos < DEF_TOGGLE_LEN) && ((pos % 2) == 0);
      case (kind)
         K_STUCK0: b = 1'b0;
         K_STUCK1: b = 1'b1;
         K_FLIP10: if (it == 9 && pos == 5) b = ~b;
         K_FLIP15: if (((it + 1) % 15) == 0 && pos == 5) b = ~b;
         default:  ;
      endcase
      return b;
   endfunction

   function automatic scen_t mk(input string nm, input int kp, input int kn, input int kt,
                                input int pp, input int pn, input int pt, input logic [2:0] f);
      scen_t s;
      s.name = nm;
      s.kp = kp; s.kn = kn; s.kt = kt;
      s.pp = pp; s.pn = pn; s.pt = pt;
      s.final_lg = f;
      return s;
   endfunction

   function automatic logic [2:0] exp_lg(input scen_t s, input int rel);
      return {rel >= s.pt, rel >= s.pn, rel >= s.pp};
   endfunction

   task automatic expect_now(input string tag, input logic [2:0] lg, input logic dn);
      exp_t e;
      e.cyc = tick_no;
      e.lg  = lg;
      e.dn  = dn;
      e.tag = tag;
      sb_q.push_back(e);
   endtask

   task automatic tick(input logic r, input logic e_, input logic c,
                       input logic p, input logic n, input logic t);
      rst  = r;
      en   = e_;
      clr  = c;
      rckp = p;
      rckn = n;
      rtrk = t;
      @(posedge clk);
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= tick_no) begin
         exp_t e;
         e = sb_q.pop_front();
         n_cmp++;
         if (e.cyc != tick_no || logged !== e.lg || done !== e.dn) begin
            n_bad++;
            $display("FAIL %s (tick %0d): got logged=%b done=%b, want logged=%b done=%b",
                     e.tag, tick_no, logged, done, e.lg, e.dn);
         end
      end
      tick_no++;
   endtask

   task automatic rnd_tick(input logic r, input logic e_, input logic c);
      tick(r, e_, c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   task automatic win_tick(input int rel, input int kp, input int kn, input int kt, input logic c);
      tick(1'b0, 1'b1, c, pat_bit(kp, rel), pat_bit(kn, rel), pat_bit(kt, rel));
   endtask

   task automatic run_scen(input scen_t s);
      expect_now({s.name, "_reset"}, 3'b000, 1'b0);
      rnd_tick(1'b1, 1'b1, 1'b1);
      expect_now({s.name, "_idle"}, 3'b000, 1'b0);
      rnd_tick(1'b0, 1'b0, 1'b0);
      for (int rel = 0; rel < WIN + 20; rel++) begin
         if (rel == s.pp - 1 || rel == s.pp || rel == s.pn - 1 || rel == s.pn ||
             rel == s.pt - 1 || rel == s.pt || rel == WIN - 2 || rel == WIN - 1 ||
             (rel % 400) == 0 || rel == WIN + 19)
            expect_now($sformatf("%s_t%0d", s.name, rel), exp_lg(s, rel), rel >= WIN - 1);
         if (rel < WIN) win_tick(rel, s.kp, s.kn, s.kt, 1'b0);
         else           rnd_tick(1'b0, 1'b1, 1'b0);
      end
      expect_now({s.name, "_final"}, s.final_lg, 1'b0);
      rnd_tick(1'b0, 1'b0, 1'b0);
   endtask

   scen_t scen[5];

   initial begin
      scen[0] = mk("ideal",       K_IDEAL,  K_IDEAL,  K_IDEAL,  384,   384,   384,   3'b111);
      scen[1] = mk("rckn_stuck0", K_IDEAL,  K_STUCK0, K_IDEAL,  384,   NEVER, 384,   3'b101);
      scen[2] = mk("rtrk_flip10", K_IDEAL,  K_IDEAL,  K_FLIP10, 384,   384,   624,   3'b111);
      scen[3] = mk("rtrk_flip15", K_IDEAL,  K_IDEAL,  K_FLIP15, 384,   384,   NEVER, 3'b011);
      scen[4] = mk("stuck_mix",   K_STUCK1, K_IDEAL,  K_STUCK0, NEVER, 384,   NEVER, 3'b010);

      for (int i = 0; i < 5; i++) run_scen(scen[i]);

      // clear colliding with the pass event: clear wins, pass needs 16 more iterations
      expect_now("clr_reset", 3'b000, 1'b0);
      rnd_tick(1'b1, 1'b0, 1'b0);
      for (int rel = 0; rel <= 800; rel++) begin
         if (rel == 383) expect_now("clr_before", 3'b000, 1'b0);
         if (rel == 384) expect_now("clr_wins", 3'b000, 1'b0);
         if (rel == 767) expect_now("clr_repass_early", 3'b000, 1'b0);
         if (rel == 768) expect_now("clr_repass", 3'b111, 1'b0);
         win_tick(rel, K_IDEAL, K_IDEAL, K_IDEAL, rel == 384);
      end
      expect_now("clr_retained_idle", 3'b111, 1'b0);
      rnd_tick(1'b0, 1'b0, 1'b0);
      expect_now("clr_while_idle", 3'b000, 1'b0);
      rnd_tick(1'b0, 1'b0, 1'b1);

      // reset mid-window aborts it; the next window counts from the release
      expect_now("rstw_reset", 3'b000, 1'b0);
      rnd_tick(1'b1, 1'b0, 1'b0);
      for (int rel = 0; rel < 1000; rel++) begin
         if (rel == 384) expect_now("rstw_pass", 3'b111, 1'b0);
         if (rel == 999) expect_now("rstw_pre_reset", 3'b111, 1'b0);
         win_tick(rel, K_IDEAL, K_IDEAL, K_IDEAL, 1'b0);
      end
      expect_now("rstw_reset_mid", 3'b000, 1'b0);
      rnd_tick(1'b1, 1'b1, 1'b1);
      expect_now("rstw_reset_hold", 3'b000, 1'b0);
      rnd_tick(1'b1, 1'b1, 1'b0);
      for (int rel = 0; rel < WIN; rel++) begin
         if (rel == 383)     expect_now("rstw_new_prepass", 3'b000, 1'b0);
         if (rel == 384)     expect_now("rstw_new_pass", 3'b111, 1'b0);
         if (rel == WIN - 2) expect_now("rstw_done_early", 3'b111, 1'b0);
         if (rel == WIN - 1) expect_now("rstw_done", 3'b111, 1'b1);
         win_tick(rel, K_IDEAL, K_IDEAL, K_IDEAL, 1'b0);
      end
      expect_now("rstw_drop", 3'b111, 1'b0);
      rnd_tick(1'b0, 1'b0, 1'b0);

      // enable dropping mid-burst discards the partial run count
      expect_now("abandon_reset", 3'b000, 1'b0);
      rnd_tick(1'b1, 1'b0, 1'b0);
      for (int rel = 0; rel < 370; rel++) begin
         if (rel == 369) expect_now("abandon_mid", 3'b000, 1'b0);
         win_tick(rel, K_IDEAL, K_IDEAL, K_IDEAL, 1'b0);
      end
      expect_now("abandon_off", 3'b000, 1'b0);
      rnd_tick(1'b0, 1'b0, 1'b0);
      rnd_tick(1'b0, 1'b0, 1'b0);
      rnd_tick(1'b0, 1'b0, 1'b0);
      for (int rel = 0; rel <= 400; rel++) begin
         if (rel == 24)  expect_now("abandon_no_carry", 3'b000, 1'b0);
         if (rel == 383) expect_now("abandon_prepass", 3'b000, 1'b0);
         if (rel == 384) expect_now("abandon_pass", 3'b111, 1'b0);
         win_tick(rel, K_IDEAL, K_IDEAL, K_IDEAL, 1'b0);
      end
      expect_now("abandon_drop", 3'b111, 1'b0);
      rnd_tick(1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
